// File: rtl/data_mem_bridge_pkg.sv
// Shared constants and state encoding for the data-memory bridge between the
// cpu MEM stage and a variable-latency backing memory.
package data_mem_bridge_pkg;

  localparam int DATA_WIDTH_C = 32;
  localparam int STRB_WIDTH_C = DATA_WIDTH_C / 8;
  // Byte-offset bits below the word tag.
  localparam int TAG_LSB      = $clog2(STRB_WIDTH_C);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_line_buf.sv
// One-word read buffer with tag/valid, hit compare, fill from the backing
// memory and byte-strobe merge of completed stores.
module data_mem_line_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 30,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  hit,
  input  logic                  fill_en,
  input  logic [TAG_WIDTH-1:0]  fill_tag,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  merge_en,
  input  logic [TAG_WIDTH-1:0]  merge_tag,
  input  logic [DATA_WIDTH-1:0] merge_data,
  input  logic [STRB_WIDTH-1:0] merge_strb,
  output logic [DATA_WIDTH-1:0] buf_data
);

  logic                  valid_q, valid_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] merged;
  logic                  merge_hit;

  assign hit       = valid_q && (lookup_tag == tag_q);
  assign merge_hit = valid_q && (merge_tag == tag_q);
  assign buf_data  = data_q;

  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = merge_strb[gi] ? merge_data[gi*8 +: 8] : data_q[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end else if (merge_en && merge_hit) begin
      data_d  = merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Turns the cpu's single-cycle data-memory view into a level-held req/ack
// handshake, stalling the pipeline on misses and stores until acknowledged.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_C,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst_n,
  input  logic                       cpu_data_mem_read,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
  input  logic                       cpu_data_mem_write,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
  input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
  input  logic [STRB_WIDTH-1:0]      cpu_data_mem_write_strobe,
  output logic [DATA_WIDTH-1:0]      data_mem_rdata,
  output logic                       data_mem_hazard,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [STRB_WIDTH-1:0]      mem_wstrb,
  input  logic                       mem_ack,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  localparam int TAG_WIDTH = DATA_ADDR_WIDTH - TAG_LSB;
  localparam logic [DATA_ADDR_WIDTH-1:0] ALIGN_MASK = {{TAG_WIDTH{1'b1}}, {TAG_LSB{1'b0}}};

  state_e                     state_q, state_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0]      mem_wstrb_q, mem_wstrb_d;
  logic                       hazard;
  logic                       hit;
  logic                       fill_en;
  logic                       merge_en;
  logic [TAG_WIDTH-1:0]       req_tag;

  assign req_tag = mem_addr_q[DATA_ADDR_WIDTH-1:TAG_LSB];

  data_mem_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_line_buf (
    .clk        (cpu_clk),
    .rst_n      (cpu_rst_n),
    .lookup_tag (cpu_data_mem_raddr[DATA_ADDR_WIDTH-1:TAG_LSB]),
    .hit        (hit),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_data  (mem_rdata),
    .merge_en   (merge_en),
    .merge_tag  (req_tag),
    .merge_data (mem_wdata_q),
    .merge_strb (mem_wstrb_q),
    .buf_data   (data_mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    hazard      = 1'b0;
    fill_en     = 1'b0;
    merge_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // Stores win over a simultaneous load; a load hit completes with no stall.
        if (cpu_rst_n && cpu_data_mem_write) begin
          hazard      = 1'b1;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cpu_data_mem_waddr & ALIGN_MASK;
          mem_wdata_d = cpu_data_mem_wdata;
          mem_wstrb_d = cpu_data_mem_write_strobe;
        end else if (cpu_rst_n && cpu_data_mem_read && !hit) begin
          hazard      = 1'b1;
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = cpu_data_mem_raddr & ALIGN_MASK;
          mem_wstrb_d = '0;
        end
      end
      REQ: begin
        hazard = 1'b1;
        if (mem_ack && mem_req_q) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          merge_en  = mem_we_q;
          fill_en   = !mem_we_q;
        end
      end
      // The stalled request is still on the inputs here; release the pipeline without reissuing.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign data_mem_hazard = hazard;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_wstrb       = mem_wstrb_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: a transaction-level buffer/stall model
// checked every cycle, plus literal pins on the key scenarios.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] raddr = '0;
  logic        wr = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  strb = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] data_mem_rdata;
  logic        data_mem_hazard;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the one-word buffer.
  bit          m_valid = 1'b0;
  logic [29:0] m_tag = '0;
  logic [31:0] m_data = '0;

  // Current transaction as seen by the model.
  bit          chk_en = 1'b0;
  bit          op_active = 1'b0;
  bit          cur_read = 1'b0;
  bit          cur_write = 1'b0;
  bit          cur_miss = 1'b0;
  int          cur_k = 0;
  int          cur_delay = 0;
  logic [31:0] cur_raddr = '0;
  logic [31:0] cur_waddr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_strb = '0;
  int          pin_sel = 0;

  // Observations owned by the compare process.
  int          hz_run = 0;
  int          last_run = 0;
  logic [31:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [3:0]  last_wstrb = '0;
  logic        exp_hz;
  logic        exp_req;

  data_mem_bridge dut (
    .cpu_clk                   (clk),
    .cpu_rst_n                 (rst_n),
    .cpu_data_mem_read         (rd),
    .cpu_data_mem_raddr        (raddr),
    .cpu_data_mem_write        (wr),
    .cpu_data_mem_waddr        (waddr),
    .cpu_data_mem_wdata        (wdata),
    .cpu_data_mem_write_strobe (strb),
    .data_mem_rdata            (data_mem_rdata),
    .data_mem_hazard           (data_mem_hazard),
    .mem_req                   (mem_req),
    .mem_we                    (mem_we),
    .mem_addr                  (mem_addr),
    .mem_wdata                 (mem_wdata),
    .mem_wstrb                 (mem_wstrb),
    .mem_ack                   (mem_ack),
    .mem_rdata                 (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hz_run = 0;
    end else begin
      if (data_mem_hazard) hz_run++;
      else begin
        if (hz_run != 0) last_run = hz_run;
        hz_run = 0;
      end
      if (mem_req) begin
        last_addr  = mem_addr;
        last_we    = mem_we;
        last_wstrb = mem_wstrb;
      end
    end

    if (rst_n && chk_en) begin
      exp_hz  = op_active && cur_miss && (cur_k < 2 + cur_delay);
      exp_req = op_active && cur_miss && (cur_k >= 1) && (cur_k <= 1 + cur_delay);
      chk("hazard", {31'b0, data_mem_hazard}, {31'b0, exp_hz});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
      chk("rdata", data_mem_rdata, m_data);
      if (exp_req) begin
        chk("mem_we", {31'b0, mem_we}, {31'b0, cur_write});
        chk("mem_addr", mem_addr, (cur_write ? cur_waddr : cur_raddr) & 32'hFFFF_FFFC);
        if (cur_write) begin
          chk("mem_wdata", mem_wdata, cur_wdata);
          chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, cur_strb});
        end
      end
    end

    case (pin_sel)
      1: begin
        chk("rst_hazard", {31'b0, data_mem_hazard}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("rst_rdata", data_mem_rdata, 32'd0);
      end
      2: begin
        chk("load100_rdata", data_mem_rdata, 32'hDEAD_BEEF);
        chk("load100_stall", last_run, 32'd5);
        chk("load100_addr", last_addr, 32'h0000_0100);
        chk("load100_we", {31'b0, last_we}, 32'd0);
      end
      3: begin
        chk("hit102_rdata", data_mem_rdata, 32'hDEAD_BEEF);
        chk("hit102_hazard", {31'b0, data_mem_hazard}, 32'd0);
        chk("hit102_req", {31'b0, mem_req}, 32'd0);
      end
      4: begin
        chk("store100_stall", last_run, 32'd2);
        chk("store100_we", {31'b0, last_we}, 32'd1);
        chk("store100_wstrb", {28'b0, last_wstrb}, 32'h2);
        chk("store100_addr", last_addr, 32'h0000_0100);
      end
      5: begin
        chk("merge_rdata", data_mem_rdata, 32'hDEAD_AAEF);
        chk("merge_hazard", {31'b0, data_mem_hazard}, 32'd0);
      end
      6: begin
        chk("store200_keep", data_mem_rdata, 32'hDEAD_AAEF);
        chk("store200_addr", last_addr, 32'h0000_0200);
      end
      7: begin
        chk("miss204_addr", last_addr, 32'h0000_0204);
        chk("miss204_rdata", data_mem_rdata, 32'h0BAD_F00D);
      end
      8: begin
        chk("inreq_req", {31'b0, mem_req}, 32'd1);
        chk("inreq_hazard", {31'b0, data_mem_hazard}, 32'd1);
        chk("inreq_addr", mem_addr, 32'h0000_0400);
      end
      10: begin
        chk("postrst_stall", last_run, 32'd3);
        chk("postrst_addr", last_addr, 32'h0000_0100);
        chk("postrst_rdata", data_mem_rdata, 32'h1122_3344);
      end
      11: begin
        chk("both_we", {31'b0, last_we}, 32'd1);
        chk("both_addr", last_addr, 32'h0000_0300);
        chk("both_rdata", data_mem_rdata, 32'h1122_3344);
      end
      12: begin
        chk("load300_we", {31'b0, last_we}, 32'd0);
        chk("load300_rdata", data_mem_rdata, 32'h99AA_BBCC);
      end
      default: ;
    endcase
  end

  // Presents one request; a miss or store acks dly cycles after mem_req rises.
  task automatic do_op(input bit r, input logic [31:0] ra, input bit w, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] st, input int dly,
                       input logic [31:0] mrd, input int pin);
    int total;
    rd = r; raddr = ra; wr = w; waddr = wa; wdata = wd; strb = st;
    cur_read = r; cur_write = w; cur_raddr = ra; cur_waddr = wa;
    cur_wdata = wd; cur_strb = st; cur_delay = dly;
    cur_miss = w || (r && !(m_valid && (m_tag == ra[31:2])));
    total = cur_miss ? 3 + dly : 1;
    op_active = 1'b1;
    for (int c = 0; c < total; c++) begin
      cur_k = c;
      pin_sel = (c == total - 1) ? pin : 0;
      mem_ack = cur_miss && (c == 1 + dly);
      mem_rdata = mem_ack ? (w ? 32'hBAD0_BAD0 : mrd) : 32'h0;
      @(posedge clk); #1;
      if (mem_ack) begin
        if (w) begin
          if (m_valid && (m_tag == wa[31:2]))
            for (int b = 0; b < 4; b++)
              if (st[b]) m_data[b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          m_valid = 1'b1;
          m_tag = ra[31:2];
          m_data = mrd;
        end
      end
    end
    mem_ack = 1'b0; mem_rdata = '0; op_active = 1'b0; pin_sel = 0;
    rd = 1'b0; wr = 1'b0; raddr = '0; waddr = '0; wdata = '0; strb = '0;
    $display("op r=%0d ra=%h w=%0d wa=%h wd=%h st=%b dly=%0d miss=%0d", r, ra, w, wa, wd, st, dly, cur_miss);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    pin_sel = 1;
    repeat (2) @(posedge clk);
    #1;
    pin_sel = 0;
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 2);
    do_op(1'b1, 32'h102, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 3);
    do_op(1'b0, 32'h0, 1'b1, 32'h100, 32'h0000_AA00, 4'b0010, 0, 32'h0, 4);
    do_op(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 5);
    idle(2);
    do_op(1'b0, 32'h0, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 1, 32'h0, 6);
    do_op(1'b1, 32'h204, 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 7);
    do_op(1'b1, 32'h207, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
    do_op(1'b0, 32'h0, 1'b1, 32'h205, 32'hAA00_00BB, 4'b1001, 1, 32'h0, 0);
    do_op(1'b1, 32'h204, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0);
    idle(1);

    // Reset while a miss is waiting for its ack.
    chk_en = 1'b0;
    rd = 1'b1; raddr = 32'h400;
    @(posedge clk); #1;
    pin_sel = 8;
    @(posedge clk); #1;
    rst_n = 1'b0;
    pin_sel = 1;
    @(posedge clk); #1;
    pin_sel = 0;
    rd = 1'b0; raddr = '0;
    rst_n = 1'b1;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    chk_en = 1'b1;
    $display("op reset asserted during pending load 0x400");

    do_op(1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h1122_3344, 10);
    do_op(1'b1, 32'h300, 1'b1, 32'h300, 32'h5566_7788, 4'hF, 0, 32'hFFFF_FFFF, 11);
    do_op(1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h99AA_BBCC, 12);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
